imem_bus_responder: RTL and testbench
=====================================

// Module: imem_bus_responder
// PURPOSE
//  Memory-side responder on the interconnect bus that the cache controllers use as initiators.
//  It accepts a read request and returns one line as BEATS back-to-back 32-bit beats after a fixed LATENCY.
//  It accepts a single-word write and acknowledges it with a one-cycle mem_data_valid pulse.
//  Backing store is an internal word array. The block stands in for main memory in sim and sits behind the arbiter.
// PARAMETERS
//  DATAW      32  bus data width (one beat)
//  ADDRW      32  bus byte-address width
//  DEPTH_LOG2 10  log2 of array depth in DATAW words
//  BEATS      4   beats per read line (16B line at DATAW=32)
//  LATENCY    3   cycles from request acceptance to first response; legal range 1..15
// PORTS
//  clk            in   1      clock; all state changes on rising edge
//  reset          in   1      asynchronous, active-low reset
//  mem_en         in   1      initiator owns the bus; qualifies every other input
//  mem_req        in   1      request strobe, sampled only in IDLE
//  mem_rd_wr      in   1      0 = line read, 1 = single-word write
//  mem_addr       in   ADDRW  byte address of the request
//  mem_wr_data    in   DATAW  write data, sampled with the request
//  mem_data_valid out  1      read beat valid, or write acknowledge pulse
//  mem_data       out  DATAW  read beat data; 0 when mem_data_valid=0 and on write acks
//  resp_busy      out  1      high in any state other than IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, counters=0, mem_data_valid=0, mem_data=0, resp_busy=0.
//    Array contents are NOT cleared.
//  - Word index = mem_addr[DEPTH_LOG2+1:2]. Higher address bits alias (modulo DEPTH). Bits [1:0] are ignored.
//  - Read base = word index with its low log2(BEATS) bits cleared (line-aligned). Beat i reads base+i.
//    The index wraps modulo DEPTH.
//  - Accept: at an edge E0 where state=IDLE and mem_en=1 and mem_req=1.
//    On accept, latch the address, rd_wr and wr_data, load lat_cnt=LATENCY-1, and go to WAIT.
//  - WAIT: decrement lat_cnt each edge. On the edge with lat_cnt=0, go to RD_BURST (read) or WR_ACK (write).
//    With LATENCY=1, WAIT lasts exactly one cycle.
//  - Timing: the first response is visible in the cycle after edge E0+LATENCY.
//  - RD_BURST: mem_data_valid=1 for BEATS consecutive cycles, beat 0 first.
//    mem_data is registered from the array. beat_cnt counts 0..BEATS-1, then the state returns to IDLE.
//  - WR_ACK: the array word is written on the edge entering WR_ACK. mem_data_valid=1 for exactly one cycle.
//    mem_data=0. The state then returns to IDLE.
//  - No back-pressure: the initiator must take each beat in the cycle it is presented.
//  - Requests while resp_busy=1 are ignored, not queued.
//  - Back-to-back requests: a new accept is possible on the edge that returns the state to IDLE... no:
//    acceptance requires state=IDLE at the sampling edge, so there is at least one idle cycle between transactions.
//  - Abort: if mem_en=0 at any edge in WAIT, RD_BURST or WR_ACK, go to IDLE with mem_data_valid=0 next cycle.
//    A write aborted in WAIT is not performed.
//  - Reset asserted mid-transaction: outputs go to 0 immediately (async). A pending write is dropped.
//  - X on mem_req or mem_rd_wr while idle with mem_en=1 is a protocol violation; flag it with an assertion.
// TESTING
//  1. Four writes, to 0x100/0x104/0x108/0x10C with data 0x11111111..0x44444444 -> 4 ack pulses.
//     Then read 0x100 -> valid for 4 consecutive cycles with 11..,22..,33..,44.. in order.
//     First beat appears exactly LATENCY cycles after the accept edge.
//  2. Misaligned read at 0x106 -> the same 4 beats as the read at 0x100, in the same order.
//  3. Second mem_req issued in the cycle after an accept -> ignored, resp_busy=1, exactly one burst.
//  4. mem_en dropped during beat 2 of a read -> valid=0 next cycle, state IDLE, a new read then completes.
//  5. Async reset pulsed mid-WAIT of a write of 0xDEADBEEF to 0x40 -> outputs 0 at once.
//     A later read of 0x40 does not return 0xDEADBEEF.
//  6. With DEPTH_LOG2=10, write 0xCAFEF00D to 0x1000 -> a read of 0x0 returns 0xCAFEF00D on beat 0.
//     Also sweep LATENCY in {1,15} and confirm first-beat timing.

Source files
------------

// File: rtl/imem_bus_responder.sv
// Memory-side bus responder. A read returns one line as BEATS back-to-back beats after LATENCY cycles.
// A single-word write is acknowledged with a one-cycle valid pulse. Storage is an internal word array.
module imem_bus_responder #(
    parameter int DATAW      = 32,
    parameter int ADDRW      = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int BEATS      = 4,
    parameter int LATENCY    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_en,
    input  logic             mem_req,
    input  logic             mem_rd_wr,
    input  logic [ADDRW-1:0] mem_addr,
    input  logic [DATAW-1:0] mem_wr_data,
    output logic             mem_data_valid,
    output logic [DATAW-1:0] mem_data,
    output logic             resp_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RD_BURST, WR_ACK} state_t;

    state_t                state, state_next;
    logic [LW-1:0]         lat_cnt, lat_next;
    logic [BW-1:0]         beat_cnt, beat_next, beat_sel;
    logic [DEPTH_LOG2-1:0] idx_q, line_base, rd_idx;
    logic                  rd_wr_q;
    logic [DATAW-1:0]      wr_data_q;
    logic                  accept, do_write, valid_next;
    logic [DATAW-1:0]      data_next;
    logic [DATAW-1:0]      mem_array [DEPTH];
    logic                  unused_addr_bits;

    // Only the word-index bits address the array; upper bits alias and byte offset is ignored.
    assign unused_addr_bits = ^{mem_addr[ADDRW-1:DEPTH_LOG2+2], mem_addr[1:0]};

    assign resp_busy = (state != IDLE);
    assign line_base = idx_q & ~DEPTH_LOG2'(BEATS - 1);
    assign beat_sel  = (state == RD_BURST) ? beat_cnt + BW'(1) : '0;
    assign rd_idx    = line_base + DEPTH_LOG2'(beat_sel);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        lat_next   = lat_cnt;
        beat_next  = beat_cnt;
        valid_next = 1'b0;
        data_next  = '0;
        accept     = 1'b0;
        do_write   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_en && mem_req) begin
                    accept     = 1'b1;
                    lat_next   = LW'(LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!mem_en) begin
                    state_next = IDLE;
                end else if (lat_cnt == '0) begin
                    valid_next = 1'b1;
                    if (rd_wr_q) begin
                        do_write   = 1'b1;
                        state_next = WR_ACK;
                    end else begin
                        beat_next  = '0;
                        data_next  = mem_array[rd_idx];
                        state_next = RD_BURST;
                    end
                end else begin
                    lat_next = lat_cnt - LW'(1);
                end
            end
            RD_BURST: begin
                if (!mem_en || beat_cnt == BW'(BEATS - 1)) begin
                    state_next = IDLE;
                end else begin
                    beat_next  = beat_sel;
                    valid_next = 1'b1;
                    data_next  = mem_array[rd_idx];
                end
            end
            WR_ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            beat_cnt       <= '0;
            rd_wr_q        <= 1'b0;
            idx_q          <= '0;
            wr_data_q      <= '0;
            mem_data_valid <= 1'b0;
            mem_data       <= '0;
        end else begin
            state          <= state_next;
            lat_cnt        <= lat_next;
            beat_cnt       <= beat_next;
            mem_data_valid <= valid_next;
            mem_data       <= data_next;
            if (accept) begin
                rd_wr_q   <= mem_rd_wr;
                idx_q     <= mem_addr[DEPTH_LOG2+1:2];
                wr_data_q <= mem_wr_data;
            end
        end
    end

    // NOTE: the array has no reset; contents survive reset and it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_write) mem_array[idx_q] <= wr_data_q;
    end

    a_no_x_when_idle: assert property (@(posedge clk) disable iff (!reset)
        (state == IDLE && mem_en === 1'b1) |-> !$isunknown({mem_req, mem_rd_wr}));

endmodule

// File: tb/tb_imem_bus_responder.sv
// Bench for imem_bus_responder: directed scenarios plus random traffic against a word-array model,
// with LATENCY=1 and LATENCY=15 instances sharing the stimulus for first-beat timing.
module tb_imem_bus_responder;
    localparam int LAT    = 3;
    localparam int BEATS  = 4;
    localparam int DEPTH  = 1024;
    localparam int RD_CYC = LAT + BEATS + 1;
    localparam int WR_CYC = LAT + 2;

    logic        clk = 1'b0, reset = 1'b0;
    logic        mem_en = 1'b0, mem_req = 1'b0, mem_rd_wr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wr_data = '0;
    logic        valid, valid_l1, valid_l15, busy, busy_l1, busy_l15;
    logic [31:0] data, data_l1, data_l15;

    int checks = 0, failures = 0;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    logic        cap_valid [64];
    logic        cap_busy  [64];
    logic [31:0] cap_data  [64];

    always #5 clk = ~clk;

    imem_bus_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mem_en(mem_en), .mem_req(mem_req), .mem_rd_wr(mem_rd_wr),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_data_valid(valid), .mem_data(data), .resp_busy(busy));

    imem_bus_responder #(.LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .mem_en(mem_en), .mem_req(mem_req), .mem_rd_wr(mem_rd_wr),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_data_valid(valid_l1), .mem_data(data_l1), .resp_busy(busy_l1));

    imem_bus_responder #(.LATENCY(15)) dut_l15 (
        .clk(clk), .reset(reset), .mem_en(mem_en), .mem_req(mem_req), .mem_rd_wr(mem_rd_wr),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_data_valid(valid_l15), .mem_data(data_l15), .resp_busy(busy_l15));

    // Reference model: byte address -> word slot, line-aligned beats, wrap modulo DEPTH.
    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic int line_word(input logic [31:0] a, input int beat);
        return ((word_of(a) / BEATS) * BEATS + beat) % DEPTH;
    endfunction

    // Expected outputs k cycles after the cycle following the accept edge.
    task automatic model_read(input logic [31:0] a, input int k, output logic ev,
                              output logic [31:0] ed, output logic eb, output bit kn);
        ev = (k >= LAT) && (k < LAT + BEATS);
        eb = (k < LAT + BEATS);
        ed = '0;
        kn = 1'b1;
        if (ev) begin
            ed = ref_mem[line_word(a, k - LAT)];
            kn = ref_known[line_word(a, k - LAT)];
        end
    endtask

    task automatic model_write(input int k, output logic ev, output logic [31:0] ed, output logic eb);
        ev = (k == LAT);
        eb = (k <= LAT);
        ed = '0;
    endtask

    // Issues one request from IDLE and records outputs on the following ncyc negedges.
    task automatic run_txn(input logic rw, input logic [31:0] a, input logic [31:0] d, input int ncyc);
        mem_en = 1'b1; mem_req = 1'b1; mem_rd_wr = rw; mem_addr = a; mem_wr_data = d;
        @(negedge clk);
        mem_req = 1'b0; mem_rd_wr = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            cap_valid[k] = valid; cap_data[k] = data; cap_busy[k] = busy;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || data !== 32'h0 || busy !== 1'b0 ||
            valid_l1 !== 1'b0 || busy_l1 !== 1'b0 || valid_l15 !== 1'b0 || busy_l15 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h b=%b, want 0/0/0", valid, data, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_idle: got v=%b b=%b, want 0/0", valid, busy);
        end
    endtask

    task automatic test_write_read();
        logic ev, eb; logic [31:0] ed, a, d; bit kn;
        for (int i = 0; i < 4; i++) begin
            a = 32'h100 + 32'(4 * i);
            d = 32'h1111_1111 * 32'(i + 1);
            run_txn(1'b1, a, d, WR_CYC);
            for (int k = 0; k < WR_CYC; k++) begin
                model_write(k, ev, ed, eb);
                checks++;
                if (cap_valid[k] !== ev || cap_busy[k] !== eb || cap_data[k] !== ed) begin
                    failures++;
                    $display("FAIL write_ack[%0d] cyc%0d: got v=%b b=%b d=%h, want v=%b b=%b d=%h",
                             i, k, cap_valid[k], cap_busy[k], cap_data[k], ev, eb, ed);
                end
            end
            ref_mem[word_of(a)] = d; ref_known[word_of(a)] = 1'b1;
        end
        run_txn(1'b0, 32'h100, 32'h0, RD_CYC);
        for (int k = 0; k < RD_CYC; k++) begin
            model_read(32'h100, k, ev, ed, eb, kn);
            checks++;
            if (cap_valid[k] !== ev || cap_busy[k] !== eb || (kn && cap_data[k] !== ed)) begin
                failures++;
                $display("FAIL read_0x100 cyc%0d: got v=%b b=%b d=%h, want v=%b b=%b d=%h",
                         k, cap_valid[k], cap_busy[k], cap_data[k], ev, eb, ed);
            end
        end
    endtask

    task automatic test_misaligned();
        logic ev, eb; logic [31:0] ed; bit kn;
        run_txn(1'b0, 32'h106, 32'h0, RD_CYC);
        for (int k = 0; k < RD_CYC; k++) begin
            model_read(32'h106, k, ev, ed, eb, kn);
            checks++;
            if (cap_valid[k] !== ev || cap_busy[k] !== eb || (kn && cap_data[k] !== ed)) begin
                failures++;
                $display("FAIL read_0x106 cyc%0d: got v=%b b=%b d=%h, want v=%b b=%b d=%h",
                         k, cap_valid[k], cap_busy[k], cap_data[k], ev, eb, ed);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int nbeats = 0;
        mem_en = 1'b1; mem_req = 1'b1; mem_rd_wr = 1'b0; mem_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_accept: got %b, want 1", busy);
        end
        mem_addr = 32'h200;
        @(negedge clk);
        mem_req = 1'b0;
        for (int k = 1; k < 2 * (LAT + BEATS) + 4; k++) begin
            if (valid === 1'b1) begin
                if (nbeats < BEATS) begin
                    checks++;
                    if (data !== ref_mem[line_word(32'h100, nbeats)]) begin
                        failures++;
                        $display("FAIL ignore_busy_beat%0d: got %h, want %h",
                                 nbeats, data, ref_mem[line_word(32'h100, nbeats)]);
                    end
                end
                nbeats++;
            end
            @(negedge clk);
        end
        checks++;
        if (nbeats != BEATS) begin
            failures++;
            $display("FAIL ignore_busy_beat_count: got %0d, want %0d", nbeats, BEATS);
        end
    endtask

    task automatic test_abort();
        logic ev, eb; logic [31:0] ed; bit kn;
        mem_en = 1'b1; mem_req = 1'b1; mem_rd_wr = 1'b0; mem_addr = 32'h104;
        @(negedge clk);
        mem_req = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data !== ref_mem[line_word(32'h104, 2)]) begin
            failures++;
            $display("FAIL abort_beat2: got v=%b d=%h, want v=1 d=%h", valid, data, ref_mem[line_word(32'h104, 2)]);
        end
        mem_en = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== 32'h0) begin
            failures++;
            $display("FAIL abort_next: got v=%b b=%b d=%h, want 0/0/0", valid, busy, data);
        end
        mem_en = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_stays_idle: got v=%b b=%b, want 0/0", valid, busy);
        end
        run_txn(1'b0, 32'h10C, 32'h0, RD_CYC);
        for (int k = 0; k < RD_CYC; k++) begin
            model_read(32'h10C, k, ev, ed, eb, kn);
            checks++;
            if (cap_valid[k] !== ev || cap_busy[k] !== eb || (kn && cap_data[k] !== ed)) begin
                failures++;
                $display("FAIL read_after_abort cyc%0d: got v=%b b=%b d=%h, want v=%b b=%b d=%h",
                         k, cap_valid[k], cap_busy[k], cap_data[k], ev, eb, ed);
            end
        end
    endtask

    task automatic test_async_reset();
        logic ev, eb; logic [31:0] ed, d; bit kn;
        for (int i = 0; i < BEATS; i++) begin
            d = $urandom();
            run_txn(1'b1, 32'h40 + 32'(4 * i), d, WR_CYC);
            checks++;
            if (cap_valid[LAT] !== 1'b1) begin
                failures++;
                $display("FAIL prefill_ack%0d: got v=%b, want 1", i, cap_valid[LAT]);
            end
            ref_mem[word_of(32'h40 + 32'(4 * i))] = d; ref_known[word_of(32'h40 + 32'(4 * i))] = 1'b1;
        end
        mem_en = 1'b1; mem_req = 1'b1; mem_rd_wr = 1'b1; mem_addr = 32'h40; mem_wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_req = 1'b0; mem_rd_wr = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== 32'h0) begin
            failures++;
            $display("FAIL reset_in_wait: got v=%b b=%b d=%h, want 0/0/0", valid, busy, data);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 32'h40;
        @(negedge clk);
        mem_req = 1'b0;
        repeat (LAT) @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL burst_before_reset: got v=%b, want 1", valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== 32'h0) begin
            failures++;
            $display("FAIL reset_in_burst: got v=%b b=%b d=%h, want 0/0/0", valid, busy, data);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 32'h40, 32'h0, RD_CYC);
        checks++;
        if (cap_data[LAT] === 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL dropped_write_visible: got %h, want anything but deadbeef", cap_data[LAT]);
        end
        for (int k = 0; k < RD_CYC; k++) begin
            model_read(32'h40, k, ev, ed, eb, kn);
            checks++;
            if (cap_valid[k] !== ev || cap_busy[k] !== eb || (kn && cap_data[k] !== ed)) begin
                failures++;
                $display("FAIL read_0x40 cyc%0d: got v=%b b=%b d=%h, want v=%b b=%b d=%h",
                         k, cap_valid[k], cap_busy[k], cap_data[k], ev, eb, ed);
            end
        end
    endtask

    task automatic test_alias();
        run_txn(1'b1, 32'h1000, 32'hCAFE_F00D, WR_CYC);
        ref_mem[word_of(32'h1000)] = 32'hCAFE_F00D; ref_known[word_of(32'h1000)] = 1'b1;
        run_txn(1'b0, 32'h0, 32'h0, RD_CYC);
        checks++;
        if (cap_valid[LAT] !== 1'b1 || cap_data[LAT] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL alias_beat0: got v=%b d=%h, want v=1 d=cafef00d", cap_valid[LAT], cap_data[LAT]);
        end
    endtask

    task automatic test_random();
        logic ev, eb, rw; logic [31:0] ed, a, d; bit kn;
        for (int n = 0; n < 30; n++) begin
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            d  = $urandom();
            run_txn(rw, a, d, rw ? WR_CYC : RD_CYC);
            for (int k = 0; k < (rw ? WR_CYC : RD_CYC); k++) begin
                if (rw) begin
                    model_write(k, ev, ed, eb);
                    kn = 1'b1;
                end else begin
                    model_read(a, k, ev, ed, eb, kn);
                end
                checks++;
                if (cap_valid[k] !== ev || cap_busy[k] !== eb || (kn && cap_data[k] !== ed)) begin
                    failures++;
                    $display("FAIL random[%0d] %s a=%h cyc%0d: got v=%b b=%b d=%h, want v=%b b=%b d=%h",
                             n, rw ? "wr" : "rd", a, k, cap_valid[k], cap_busy[k], cap_data[k], ev, eb, ed);
                end
            end
            if (rw) begin
                ref_mem[word_of(a)] = d; ref_known[word_of(a)] = 1'b1;
            end
        end
    endtask

    task automatic test_latency_sweep();
        int          first [3];
        int          want  [3];
        logic [31:0] fdata [3];
        logic [31:0] v;
        want  = '{1, LAT, 15};
        first = '{-1, -1, -1};
        fdata = '{32'h0, 32'h0, 32'h0};
        v = $urandom();
        mem_en = 1'b1; mem_req = 1'b0;
        repeat (20) @(negedge clk);
        mem_req = 1'b1; mem_rd_wr = 1'b1; mem_addr = 32'h300; mem_wr_data = v;
        @(negedge clk);
        mem_req = 1'b0; mem_rd_wr = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || busy_l1 !== 1'b0 || busy_l15 !== 1'b0) begin
            failures++;
            $display("FAIL sweep_idle: got b=%b/%b/%b, want 0/0/0", busy_l1, busy, busy_l15);
        end
        mem_req = 1'b1; mem_addr = 32'h300;
        @(negedge clk);
        mem_req = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (first[0] < 0 && valid_l1 === 1'b1)  begin first[0] = k; fdata[0] = data_l1;  end
            if (first[1] < 0 && valid === 1'b1)     begin first[1] = k; fdata[1] = data;     end
            if (first[2] < 0 && valid_l15 === 1'b1) begin first[2] = k; fdata[2] = data_l15; end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (first[i] != want[i] || fdata[i] !== v) begin
                failures++;
                $display("FAIL first_beat_lat%0d: got cyc=%0d d=%h, want cyc=%0d d=%h",
                         want[i], first[i], fdata[i], want[i], v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_ignore_busy();
        test_abort();
        test_async_reset();
        test_alias();
        test_random();
        test_latency_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
